// File: rtl/lcd_write_engine_pkg.sv
// lcd_pkg: shared state encoding, LCD command constants and the queued
// {RS,data} entry type used by the LCD write engine and its command FIFO.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        WAIT
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    // Larger of two timing parameters, used to size the shared down-counter.
    function automatic int lcdMax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_write_engine_if.sv
// Host-side write handshake of the LCD write engine. The sequencer drives the
// master side; the engine is the slave.
interface lcd_write_engine_if;
    logic [7:0] iDATA;
    logic       iRS;
    logic       iValid;
    logic       oReady;
    logic       oDone;
    logic       oIdle;

    modport master (output iDATA, iRS, iValid, input oReady, oDone, oIdle);
    modport slave  (input iDATA, iRS, iValid, output oReady, oDone, oIdle);
endinterface

// File: rtl/lcd_write_engine_fifo.sv
// lcd_cmd_fifo: small synchronous {RS,data} FIFO that lets the sequencer queue
// writes ahead of the LCD strobe engine. DEPTH must be a power of two (>=2).
// Read data is presented combinationally from the head entry.
import lcd_pkg::*;

module lcd_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iPush,
    input  lcd_entry_t iPushData,
    input  logic       iPop,
    output lcd_entry_t oPopData,
    output logic       oFull,
    output logic       oEmpty
);
    localparam int AW = $clog2(DEPTH);

    lcd_entry_t      r_mem [DEPTH];
    logic   [AW:0]   r_wrPtr;
    logic   [AW:0]   r_rdPtr;
    logic            w_doPush;
    logic            w_doPop;

    assign oEmpty   = (r_wrPtr == r_rdPtr);
    assign oFull    = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign oPopData = r_mem[r_rdPtr[AW-1:0]];
    assign w_doPush = iPush && !oFull;
    assign w_doPop  = iPop && !oEmpty;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge iCLK) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[AW-1:0]] <= iPushData;
        end
    end

    // Read/write pointers with a wrap bit to tell full from empty.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end
endmodule

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: HD44780-style write engine. Takes (RS, byte) writes over a
// valid/ready handshake, generates setup / enable / hold timing on the LCD
// pins in 8-bit or 4-bit (two nibble) mode, then waits a post-write execution
// delay (long for clear/home) before pulsing oDone.
// Optional feature macro: LCD_FIFO_EN adds a FIFO_DEPTH-entry command queue.
import lcd_pkg::*;

module lcd_write_engine #(
    parameter int BUS_4BIT        = 0,
    parameter int SETUP_CYC       = 2,
    parameter int EN_HIGH_CYC     = 16,
    parameter int HOLD_CYC        = 2,
    parameter int SHORT_DELAY_CYC = 2000,
    parameter int LONG_DELAY_CYC  = 82000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    lcd_write_engine_if.slave   host,
    output logic [7:0]          LCD_DATA,
    output logic                LCD_RW,
    output logic                LCD_EN,
    output logic                LCD_RS
);
    localparam int MAX_CYC = lcdMax(lcdMax(lcdMax(SETUP_CYC, EN_HIGH_CYC), HOLD_CYC),
                                    lcdMax(SHORT_DELAY_CYC, LONG_DELAY_CYC));
    localparam int CW      = $clog2(MAX_CYC) + 1;

    lcd_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_rs;
    logic [7:0]      r_data;
    logic            r_secondNibble;
    logic            r_done;
    logic            r_en;
    logic            r_lcdRs;
    logic [7:0]      r_lcdData;

    logic            w_isIdle;
    logic            w_start;
    lcd_entry_t      w_startEntry;
    logic            w_longDelay;
    logic            w_lastCycle;

    assign w_isIdle    = (r_state == IDLE);
    assign w_lastCycle = (r_cnt == CW'(1));
    assign w_longDelay = !r_rs && ((r_data == LCD_CMD_CLEAR) || (r_data == LCD_CMD_HOME));

`ifdef LCD_FIFO_EN
    logic            w_full;
    logic            w_empty;
    lcd_entry_t      w_pushEntry;

    assign w_pushEntry = '{rs: host.iRS, data: host.iDATA};
    assign w_start     = w_isIdle && !w_empty;

    lcd_cmd_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iPush      (host.iValid),
        .iPushData  (w_pushEntry),
        .iPop       (w_start),
        .oPopData   (w_startEntry),
        .oFull      (w_full),
        .oEmpty     (w_empty)
    );

    assign host.oReady = !w_full;
    assign host.oIdle  = w_isIdle && w_empty;
`else
    assign w_start      = w_isIdle && host.iValid;
    assign w_startEntry = '{rs: host.iRS, data: host.iDATA};
    assign host.oReady  = w_isIdle;
    assign host.oIdle   = w_isIdle;
`endif

    assign host.oDone = r_done;
    assign LCD_DATA   = r_lcdData;
    assign LCD_RS     = r_lcdRs;
    assign LCD_EN     = r_en;
    assign LCD_RW     = 1'b0;

    // Write sequencer: every state is held for its reload count, the strobe
    // and bus pins are registered, and oDone marks the cycle after WAIT ends.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_rs           <= 1'b0;
            r_data         <= '0;
            r_secondNibble <= 1'b0;
            r_done         <= 1'b0;
            r_en           <= 1'b0;
            r_lcdRs        <= 1'b0;
            r_lcdData      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_rs           <= w_startEntry.rs;
                        r_data         <= w_startEntry.data;
                        r_secondNibble <= 1'b0;
                        r_lcdRs        <= w_startEntry.rs;
                        r_lcdData      <= (BUS_4BIT != 0) ? {w_startEntry.data[7:4], 4'h0}
                                                          : w_startEntry.data;
                        r_cnt          <= CW'(SETUP_CYC);
                        r_state        <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_lastCycle) begin
                        r_en    <= 1'b1;
                        r_cnt   <= CW'(EN_HIGH_CYC);
                        r_state <= EN_HI;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                EN_HI: begin
                    if (w_lastCycle) begin
                        r_en    <= 1'b0;
                        r_cnt   <= CW'(HOLD_CYC);
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (w_lastCycle) begin
                        if ((BUS_4BIT != 0) && !r_secondNibble) begin
                            r_secondNibble <= 1'b1;
                            r_lcdData      <= {r_data[3:0], 4'h0};
                            r_cnt          <= CW'(SETUP_CYC);
                            r_state        <= SETUP;
                        end else begin
                            r_cnt   <= w_longDelay ? CW'(LONG_DELAY_CYC) : CW'(SHORT_DELAY_CYC);
                            r_state <= WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (w_lastCycle) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
